mem_responder: RTL

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_pkg.sv | 17 +
 rtl/dmem_array.sv | 23 ++
 rtl/mem_responder.sv | 119 +++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared types for the memory responder: FSM states, default word width, counter sizing.
package mem_pkg;

  localparam int WIDTH_DEF = 19;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } state_e;

  // A zero-wait configuration still needs a 1-bit counter to keep the datapath uniform.
  function automatic int cnt_width(input int wait_cycles);
    return (wait_cycles < 1) ? 1 : $clog2(wait_cycles + 1);
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word storage: synchronous write, asynchronous read, never reset.
module dmem_array #(
  parameter int WIDTH = 19,
  parameter int DEPTH = 256
) (
  input  logic                     clk_i,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] addr_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/mem_responder.sv
// Single-outstanding memory responder: accept in IDLE, wait WAIT_CYCLES+1 edges, then hold the
// response in RESP until rsp_ready; no new request is taken until the response handshake completes.
module mem_responder
  import mem_pkg::*;
#(
  parameter int WIDTH       = WIDTH_DEF,
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [WIDTH-1:0] req_addr,
  input  logic [WIDTH-1:0] req_wdata,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_rdata,
  output logic             rsp_err
);

  localparam int CW = cnt_width(WAIT_CYCLES);
  localparam int AW = $clog2(DEPTH);
  localparam int IW = WIDTH - 2;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             we_q, we_d;
  logic [WIDTH-1:0] addr_q, addr_d;
  logic [WIDTH-1:0] wdata_q, wdata_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic             err_q, err_d;

  logic [IW-1:0]    idx;
  logic             addr_err;
  logic             commit;
  logic             mem_we;
  logic [WIDTH-1:0] mem_rdata;

  // DEPTH is a power of two, so any index bit at or above AW means out of range.
  assign idx      = addr_q[WIDTH-1:2];
  assign addr_err = (addr_q[1:0] != 2'b00) || ((idx >> AW) != '0);
  assign commit   = (state_q == BUSY) && (cnt_q == '0);
  assign mem_we   = commit && we_q && !addr_err && !reset;

  dmem_array #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_dmem (
    .clk_i  (clk),
    .we_i   (mem_we),
    .addr_i (idx[AW-1:0]),
    .wdata_i(wdata_q),
    .rdata_o(mem_rdata)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          state_d = BUSY;
          cnt_d   = CW'(WAIT_CYCLES);
          we_d    = req_we;
          addr_d  = req_addr;
          wdata_d = req_wdata;
        end
      end
      BUSY: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          state_d = RESP;
          err_d   = addr_err;
          rdata_d = (addr_err || we_q) ? '0 : mem_rdata;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule
